// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared configuration helpers for the pipelined adder
package adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one CHUNK-bit add slice with a valid/ready register
module pipe_adder_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] b_o,
    output logic             carry_o,
    output logic             cmsb_o
);

    logic             valid_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic             carry_q;
    logic             cmsb_q;
    logic             cmsb_d;
    logic [CHUNK:0]   sum_w;
    logic             advance_w;

    assign advance_w = !valid_q || ready_i;
    assign ready_o   = advance_w;

    assign sum_w = {1'b0, acc_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_i};

    // acc rotates right one chunk per stage: the consumed a-chunk leaves at the
    // bottom and its sum enters at the top, so after the last stage acc holds the sum.
    assign acc_d  = (acc_i >> CHUNK) | (WIDTH'(sum_w[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign b_d    = (b_i >> CHUNK) | (b_i << (WIDTH - CHUNK));
    assign cmsb_d = acc_i[CHUNK-1] ^ b_i[CHUNK-1] ^ sum_w[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
        end else if (advance_w) begin
            valid_q <= valid_i;
            if (valid_i) begin
                acc_q   <= acc_d;
                b_q     <= b_d;
                carry_q <= sum_w[CHUNK];
                cmsb_q  <= cmsb_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign acc_o   = acc_q;
    assign b_o     = b_q;
    assign carry_o = carry_q;
    assign cmsb_o  = cmsb_q;

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined WIDTH-bit adder, one chunk per stage, valid/ready both sides
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic [STAGES:0]   valid_w;
    logic [STAGES:0]   ready_w;
    logic [STAGES:0]   carry_w;
    logic [STAGES-1:0] cmsb_w;
    logic [WIDTH-1:0]  acc_w [STAGES+1];
    logic [WIDTH-1:0]  b_w   [STAGES+1];
    logic              unused_w;

    assign valid_w[0]      = in_valid;
    assign acc_w[0]        = a;
    assign b_w[0]          = b;
    assign carry_w[0]      = cin;
    assign ready_w[STAGES] = out_ready;
    assign in_ready        = ready_w[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH(WIDTH),
            .CHUNK(CHUNK)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .valid_i(valid_w[k]),
            .ready_o(ready_w[k]),
            .acc_i  (acc_w[k]),
            .b_i    (b_w[k]),
            .carry_i(carry_w[k]),
            .valid_o(valid_w[k+1]),
            .ready_i(ready_w[k+1]),
            .acc_o  (acc_w[k+1]),
            .b_o    (b_w[k+1]),
            .carry_o(carry_w[k+1]),
            .cmsb_o (cmsb_w[k])
        );
    end

    assign out_valid = valid_w[STAGES];
    assign s         = acc_w[STAGES];
    assign cout      = carry_w[STAGES];
    // Last stage's carry into its top bit is the carry into the word MSB.
    assign ovf       = SIGNED ? (cmsb_w[STAGES-1] ^ carry_w[STAGES]) : 1'b0;
    assign unused_w  = ^{b_w[STAGES], cmsb_w};

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - table-driven and scoreboard bench for pipe_adder
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
    logic [15:0] a, b, s;
    int          errors = 0;
    int          checks = 0;
    logic        sweep_go = 1'b0;
    int          sweep_done = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    pipe_adder #(.WIDTH(16), .STAGES(4), .SIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {ovf, cout, s}; overflow by the same-sign-in, other-sign-out rule.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic        o;
        t = {1'b0, x} + {1'b0, y} + {16'b0, c};
        o = (x[15] == y[15]) && (t[15] != x[15]);
        return {o, t};
    endfunction

    task automatic apply_vec(input vec_t v);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; out_ready = 1'b1;
        #1 check("vec_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("vec_latency", lat, 4);
        check("vec_s", s, v.s);
        check("vec_cout", cout, v.cout);
        check("vec_ovf", ovf, v.ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[9];
        logic [17:0] q[$];
        logic [17:0] exp;
        logic [15:0] hold;
        int          stale, acc_cnt, unstable, got, sent, cyc, stall_in;
        bit          have_hold;

        vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("post_rst_in_ready", in_ready, 1);

        // Fill the pipe under backpressure, then reset mid-stream.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(16'h1000 + k); b = 16'h0001; cin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("fill_out_valid", out_valid, 1);
        check("fill_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1 check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            #1 if (out_valid) stale++;
        end
        check("no_stale", stale, 0);

        for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

        // Backpressure: 10 offers with out_ready low.
        q.delete(); acc_cnt = 0; unstable = 0; have_hold = 1'b0; hold = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1;
            a = 16'(32'h1111 * k); b = 16'(k); cin = 1'b0;
            #1;
            if (in_ready) begin
                acc_cnt++;
                q.push_back(model(a, b, cin));
            end
            if (out_valid) begin
                if (!have_hold) begin hold = s; have_hold = 1'b1; end
                else if (s !== hold) unstable++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("bp_accepted", acc_cnt, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_s_stable", unstable, 0);
        got = 0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            @(negedge clk);
            out_ready = 1'b1; cyc++;
            #1;
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                check("bp_drain", {ovf, cout, s}, exp);
                got++;
            end
        end
        check("bp_drain_count", got, 4);

        // 100 back-to-back random ops.
        q.delete(); sent = 0; got = 0; cyc = 0; stall_in = 0;
        while ((sent < 100 || got < 100) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (sent < 100) begin
                in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                check("b2b_result", {ovf, cout, s}, exp);
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin));
                sent++;
            end
            if (in_valid && !in_ready) stall_in++;
        end
        check("b2b_count", got, 100);
        check("b2b_no_stall", stall_in, 0);
        check("b2b_cycles", cyc, 104);

        sweep_go = 1'b1;
        for (int t = 0; t < 5000 && sweep_done < 3; t++) @(negedge clk);
        check("sweep_done", sweep_done, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int ST = (g == 0) ? 1 : ((g == 1) ? 2 : 16);
        logic        iv, ir, ov, orr, ci, co, of;
        logic [15:0] xa, xb, xs;

        pipe_adder #(.WIDTH(16), .STAGES(ST), .SIGNED(1'b0)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .cin(ci), .out_valid(ov), .out_ready(orr),
            .s(xs), .cout(co), .ovf(of)
        );

        initial begin
            logic [17:0] sq[$];
            logic [17:0] sexp;
            int          sgot, ssent, scyc, extra;
            string       tag;
            sgot = 0; ssent = 0; scyc = 0; extra = 0;
            tag = $sformatf("sweep_s%0d", ST);
            iv = 1'b0; orr = 1'b0; xa = '0; xb = '0; ci = 1'b0;
            wait (sweep_go);
            while (sgot < 60 && scyc < 2000) begin
                @(negedge clk);
                scyc++;
                iv  = (ssent < 60) ? 1'($urandom) : 1'b0;
                xa  = 16'($urandom); xb = 16'($urandom); ci = 1'($urandom);
                orr = 1'($urandom);
                #1;
                if (ov && orr) begin
                    if (sq.size() == 0) begin
                        check({tag, "_extra"}, sq.size(), 1);
                    end else begin
                        sexp = sq.pop_front() & 18'h1FFFF;
                        check(tag, {of, co, xs}, sexp);
                    end
                    sgot++;
                end
                if (iv && ir) begin
                    sq.push_back(model(xa, xb, ci));
                    ssent++;
                end
            end
            check({tag, "_count"}, sgot, 60);
            iv = 1'b0;
            repeat (20) begin
                @(negedge clk);
                orr = 1'b1;
                #1 if (ov) extra++;
            end
            check({tag, "_no_dup"}, extra, 0);
            sweep_done++;
        end
    end

endmodule
